// File: rtl/pc_gen_pkg.sv
// rtl/pc_gen_pkg.sv - shared types and helpers for the instruction-fetch PC generator
package if_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef enum logic {
    BRANCH = 1'b0,
    EXC    = 1'b1
  } pend_kind_t;

  // log2 of a power-of-two fetch step; also the count of forced-zero target bits
  function automatic int STEP_LSB(input int step);
    int n;
    n = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < step) n = i + 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/pc_gen_if.sv
// rtl/pc_gen_if.sv - redirect requests in, fetch address/enable out
interface pc_gen_if #(
  parameter int ADDR_W = 32
);
  logic              stall_i;
  logic              branch_flag_i;
  logic [ADDR_W-1:0] branch_address_i;
  logic              exc_flag_i;
  logic [ADDR_W-1:0] exc_address_i;
  logic [ADDR_W-1:0] pc;
  logic              ce;
  logic              redirect_pend_o;

  modport master (
    output stall_i, branch_flag_i, branch_address_i, exc_flag_i, exc_address_i,
    input  pc, ce, redirect_pend_o
  );

  modport slave (
    input  stall_i, branch_flag_i, branch_address_i, exc_flag_i, exc_address_i,
    output pc, ce, redirect_pend_o
  );
endinterface

// File: rtl/pc_redirect_pend.sv
// rtl/pc_redirect_pend.sv - holds one redirect that arrived during a stall
module pc_redirect_pend
  import if_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_cap_en,
  input  logic              i_clr,
  input  logic              i_branch_flag,
  input  logic [ADDR_W-1:0] i_branch_addr,
  input  logic              i_exc_flag,
  input  logic [ADDR_W-1:0] i_exc_addr,
  output logic              o_valid,
  output pend_kind_t        o_kind,
  output logic [ADDR_W-1:0] o_addr
);

  logic              r_valid;
  pend_kind_t        r_kind;
  logic [ADDR_W-1:0] r_addr;
  logic              w_branch_may_write;

  // a branch may replace an earlier branch but never a waiting exception
  assign w_branch_may_write = !r_valid || (r_kind == BRANCH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_kind  <= BRANCH;
      r_addr  <= '0;
    end else if (i_clr) begin
      r_valid <= 1'b0;
      r_kind  <= BRANCH;
      r_addr  <= '0;
    end else if (i_cap_en) begin
      if (i_exc_flag) begin
        r_valid <= 1'b1;
        r_kind  <= EXC;
        r_addr  <= i_exc_addr;
      end else if (i_branch_flag && w_branch_may_write) begin
        r_valid <= 1'b1;
        r_kind  <= BRANCH;
        r_addr  <= i_branch_addr;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_kind  = r_kind;
  assign o_addr  = r_addr;

endmodule

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - IF-stage PC generator with prioritised and stall-latched redirects
module pc_gen
  import if_pkg::*;
#(
  parameter int              ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = 32'h8000_0000,
  parameter int              STEP         = 4
) (
  input logic         clk,
  input logic         rst,
  pc_gen_if.slave     if_bus
);

  localparam int                LSB        = STEP_LSB(STEP);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = {ADDR_W{1'b1}} << LSB;

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_next;
  logic              r_ce;
  logic              w_ce_next;

  logic [ADDR_W-1:0] w_branch_al;
  logic [ADDR_W-1:0] w_exc_al;
  logic              w_run;
  logic              w_pend_valid;
  pend_kind_t        w_pend_kind;
  logic [ADDR_W-1:0] w_pend_addr;

  assign w_branch_al = if_bus.branch_address_i & ALIGN_MASK;
  assign w_exc_al    = if_bus.exc_address_i & ALIGN_MASK;
  assign w_run       = (r_state == RUN);

  pc_redirect_pend #(
    .ADDR_W(ADDR_W)
  ) u_pend (
    .clk           (clk),
    .rst           (rst),
    .i_cap_en      (w_run && if_bus.stall_i),
    .i_clr         (w_run && !if_bus.stall_i),
    .i_branch_flag (if_bus.branch_flag_i),
    .i_branch_addr (w_branch_al),
    .i_exc_flag    (if_bus.exc_flag_i),
    .i_exc_addr    (w_exc_al),
    .o_valid       (w_pend_valid),
    .o_kind        (w_pend_kind),
    .o_addr        (w_pend_addr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_pc    <= RESET_VECTOR;
      r_ce    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_ce    <= w_ce_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_ce_next    = r_ce;
    case (r_state)
      IDLE: begin
        w_state_next = RUN;
        w_ce_next    = 1'b1;
      end
      RUN: begin
        w_ce_next = 1'b1;
        if (!if_bus.stall_i) begin
          // live exception beats a pending redirect, which beats a live branch
          if (if_bus.exc_flag_i)         w_pc_next = w_exc_al;
          else if (w_pend_valid)         w_pc_next = w_pend_addr;
          else if (if_bus.branch_flag_i) w_pc_next = w_branch_al;
          else                           w_pc_next = r_pc + ADDR_W'(STEP);
        end
      end
      default: begin
        w_state_next = IDLE;
        w_ce_next    = 1'b0;
      end
    endcase
  end

  assign if_bus.pc              = r_pc;
  assign if_bus.ce              = r_ce;
  assign if_bus.redirect_pend_o = w_pend_valid;

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - table-driven check of pc_gen at 32-bit and 16-bit configurations
module tb_pc_gen;

  logic clk;
  logic rst;

  pc_gen_if #(.ADDR_W(32)) bus32 ();
  pc_gen_if #(.ADDR_W(16)) bus16 ();

  pc_gen #(
    .ADDR_W       (32),
    .RESET_VECTOR (32'h8000_0000),
    .STEP         (4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .if_bus (bus32.slave)
  );

  pc_gen #(
    .ADDR_W       (16),
    .RESET_VECTOR (16'hFFF8),
    .STEP         (4)
  ) dut16 (
    .clk    (clk),
    .rst    (rst),
    .if_bus (bus16.slave)
  );

  typedef struct {
    logic        stall;
    logic        bf;
    logic [31:0] ba;
    logic        ef;
    logic [31:0] ea;
    logic [31:0] exp_pc;
    logic        exp_pend;
  } vec_t;

  vec_t vq[$];
  int   total;
  int   bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic st, input logic bf, input logic [31:0] ba,
                     input logic ef, input logic [31:0] ea,
                     input logic [31:0] pc, input logic pend);
    vec_t v;
    v.stall = st; v.bf = bf; v.ba = ba; v.ef = ef; v.ea = ea;
    v.exp_pc = pc; v.exp_pend = pend;
    vq.push_back(v);
  endtask

  task automatic drive(input logic st, input logic bf, input logic [31:0] ba,
                       input logic ef, input logic [31:0] ea);
    bus32.stall_i          = st;
    bus32.branch_flag_i    = bf;
    bus32.branch_address_i = ba;
    bus32.exc_flag_i       = ef;
    bus32.exc_address_i    = ea;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    bus16.stall_i          = 1'b0;
    bus16.branch_flag_i    = 1'b0;
    bus16.branch_address_i = 16'h0;
    bus16.exc_flag_i       = 1'b0;
    bus16.exc_address_i    = 16'h0;

    //   stall bf  ba            ef  ea            pc            pend
    add(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h8000_0000, 1'b0);
    add(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h8000_0004, 1'b0);
    add(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h8000_0008, 1'b0);
    add(1'b0, 1'b1, 32'h8000_0100, 1'b0, 32'h0,        32'h8000_0100, 1'b0);
    add(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h8000_0104, 1'b0);
    add(1'b0, 1'b1, 32'h8000_0103, 1'b0, 32'h0,        32'h8000_0100, 1'b0);
    add(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h8000_0104, 1'b0);
    add(1'b1, 1'b1, 32'h8000_0200, 1'b0, 32'h0,        32'h8000_0104, 1'b1);
    add(1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h8000_0104, 1'b1);
    add(1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h8000_0104, 1'b1);
    add(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h8000_0200, 1'b0);
    add(1'b1, 1'b0, 32'h0,        1'b1, 32'h8000_0180, 32'h8000_0200, 1'b1);
    add(1'b1, 1'b1, 32'h8000_0300, 1'b0, 32'h0,        32'h8000_0200, 1'b1);
    add(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h8000_0180, 1'b0);
    add(1'b0, 1'b1, 32'h8000_0300, 1'b1, 32'h8000_0180, 32'h8000_0180, 1'b0);
    add(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h8000_0184, 1'b0);
    add(1'b1, 1'b1, 32'h8000_0400, 1'b0, 32'h0,        32'h8000_0184, 1'b1);
    add(1'b0, 1'b1, 32'h8000_0500, 1'b0, 32'h0,        32'h8000_0400, 1'b0);
    add(1'b1, 1'b1, 32'h8000_0600, 1'b0, 32'h0,        32'h8000_0400, 1'b1);
    add(1'b1, 1'b1, 32'h8000_0702, 1'b0, 32'h0,        32'h8000_0400, 1'b1);
    add(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h8000_0700, 1'b0);
    add(1'b1, 1'b0, 32'h0,        1'b1, 32'h8000_0183, 32'h8000_0700, 1'b1);
    add(1'b0, 1'b0, 32'h0,        1'b1, 32'h8000_0800, 32'h8000_0800, 1'b0);
    add(1'b1, 1'b1, 32'h8000_0A00, 1'b1, 32'h8000_0900, 32'h8000_0800, 1'b1);
    add(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h8000_0900, 1'b0);
    add(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h8000_0904, 1'b0);

    #3;
    check("reset_pc",   bus32.pc, 32'h8000_0000);
    check("reset_ce",   {31'h0, bus32.ce}, 32'h0);
    check("reset_pend", {31'h0, bus32.redirect_pend_o}, 32'h0);

    @(posedge clk); #1;
    rst = 1'b0;
    check("idle_pc", bus32.pc, 32'h8000_0000);
    check("idle_ce", {31'h0, bus32.ce}, 32'h0);

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].stall, vq[i].bf, vq[i].ba, vq[i].ef, vq[i].ea);
      @(posedge clk); #1;
      check($sformatf("vec%0d_pc", i), bus32.pc, vq[i].exp_pc);
      check($sformatf("vec%0d_ce", i), {31'h0, bus32.ce}, 32'h1);
      check($sformatf("vec%0d_pend", i), {31'h0, bus32.redirect_pend_o}, {31'h0, vq[i].exp_pend});
    end

    // asynchronous reset while a redirect is pending
    drive(1'b1, 1'b1, 32'h8000_0B00, 1'b0, 32'h0);
    @(posedge clk); #1;
    check("pre_rst_pend", {31'h0, bus32.redirect_pend_o}, 32'h1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_pc",   bus32.pc, 32'h8000_0000);
    check("async_rst_ce",   {31'h0, bus32.ce}, 32'h0);
    check("async_rst_pend", {31'h0, bus32.redirect_pend_o}, 32'h0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

    @(posedge clk); #1;
    rst = 1'b0;
    check("rst2_idle_pc", bus32.pc, 32'h8000_0000);
    check("rst2_idle_ce", {31'h0, bus32.ce}, 32'h0);
    check("w16_idle_pc",  {16'h0, bus16.pc}, 32'h0000_FFF8);
    check("w16_idle_ce",  {31'h0, bus16.ce}, 32'h0);

    @(posedge clk); #1;
    check("rst2_run_pc", bus32.pc, 32'h8000_0000);
    check("rst2_run_ce", {31'h0, bus32.ce}, 32'h1);
    check("w16_run_pc",  {16'h0, bus16.pc}, 32'h0000_FFF8);
    check("w16_run_ce",  {31'h0, bus16.ce}, 32'h1);

    @(posedge clk); #1;
    check("w16_step1", {16'h0, bus16.pc}, 32'h0000_FFFC);
    @(posedge clk); #1;
    check("w16_wrap",  {16'h0, bus16.pc}, 32'h0000_0000);
    @(posedge clk); #1;
    check("w16_after", {16'h0, bus16.pc}, 32'h0000_0004);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
